// File: rtl/syzygy_adc_pkg.sv
// -----------------------------------------------------------------------------
// syzygy_adc_pkg
//  Shared types for the ADC capture buffer: the controller state encoding and
//  the trigger-mode constants. No ports.
// -----------------------------------------------------------------------------
package syzygy_adc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      READOUT = 2'd3
   } state_t;

   localparam logic TRIG_SW     = 1'b0;  // software trigger pulse
   localparam logic TRIG_THRESH = 1'b1;  // rising crossing of the threshold

endpackage

// File: rtl/syzygy_adc_capture_if.sv
// -----------------------------------------------------------------------------
// syzygy_adc_capture_if
//  Valid/ready sample stream from the capture buffer toward the host readout.
//  Signals:
//   m_data   sample payload
//   m_valid  m_data is valid
//   m_last   final sample of the burst (qualified by m_valid)
//   m_ready  downstream accepts the current beat
//  Modports: master (capture buffer side), slave (readout side).
// -----------------------------------------------------------------------------
interface syzygy_adc_capture_if #(
   parameter int DATA_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_last;
   logic                  m_ready;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/syzygy_adc_capture_ram.sv
// -----------------------------------------------------------------------------
// syzygy_adc_capture_ram
//  Simple dual-port sample RAM: one write port, one synchronous read port with
//  read enable (data appears the cycle after re). Maps onto block RAM.
//  Ports:
//   clk    clock
//   we     write enable, waddr/wdata write address and data
//   re     read enable, raddr read address
//   rdata  registered read data
// -----------------------------------------------------------------------------
module syzygy_adc_capture_ram #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // NOTE: the array and its read register have no reset; a reset would stop
   // the tools from mapping them onto block RAM, and contents are only read
   // after being written in the same burst.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/syzygy_adc_capture.sv
// -----------------------------------------------------------------------------
// syzygy_adc_capture
//  Triggered burst capture of ADC samples into an internal RAM, followed by
//  readout over a valid/ready stream.
//  Ports:
//   clk, reset_n     sample clock, synchronous active-low reset
//   adc_data/valid   incoming samples (offset binary)
//   arm              start a capture (honoured in IDLE only)
//   abort            return to IDLE from any state, highest priority
//   trig_mode        TRIG_SW or TRIG_THRESH, latched at arm
//   sw_trigger       software trigger (TRIG_SW only)
//   trig_threshold   threshold level, latched at arm
//   capture_len      burst length; 0 or above DEPTH means DEPTH, latched at arm
//   busy             any state other than IDLE
//   done             one-cycle pulse after the final beat is accepted
//   m_if             readout stream (master)
// -----------------------------------------------------------------------------
module syzygy_adc_capture
   import syzygy_adc_pkg::*;
#(
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 1024,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_valid,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trig_mode,
   input  logic                  sw_trigger,
   input  logic [DATA_WIDTH-1:0] trig_threshold,
   input  logic [ADDR_WIDTH:0]   capture_len,
   output logic                  busy,
   output logic                  done,
   syzygy_adc_capture_if.master  m_if
);

   // Counters carry one extra bit so a full-depth count never aliases to 0.
   localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   len_q, wr_cnt_q, rd_cnt_q;
   logic                  mode_q;
   logic [DATA_WIDTH-1:0] thr_q, prev_q;
   logic                  prev_valid_q;
   logic                  done_q;

   logic                  ram_we, ram_re;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Readout pipeline: RAM read in flight, output register, skid register.
   logic                  pend_q, pend_last_q;
   logic                  out_valid_q, out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  skid_valid_q, skid_last_q;
   logic [DATA_WIDTH-1:0] skid_data_q;

   logic                  accept, crossing, wr_last, rd_last;
   logic [1:0]            in_flight;

   assign accept    = out_valid_q & m_if.m_ready;
   assign crossing  = adc_valid & prev_valid_q & (prev_q < thr_q) & (adc_data >= thr_q);
   assign wr_last   = (wr_cnt_q == len_q - CNT_ONE);
   assign rd_last   = (rd_cnt_q == len_q - CNT_ONE);
   assign in_flight = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q);

   // ---------------------------------------------------------------- FSM comb
   // NOTE: every signal written here gets its default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = wr_cnt_q[ADDR_WIDTH-1:0];

      unique case (state_q)
         IDLE: begin
            if (arm) state_d = ARMED;
         end
         ARMED: begin
            if (mode_q == TRIG_SW) begin
               if (sw_trigger) state_d = CAPTURE;
            end else if (crossing) begin
               // The crossing sample itself is sample 0 (wr_cnt_q is 0 here).
               ram_we  = 1'b1;
               state_d = (len_q == CNT_ONE) ? READOUT : CAPTURE;
            end
         end
         CAPTURE: begin
            if (adc_valid) begin
               ram_we = 1'b1;
               if (wr_last) state_d = READOUT;
            end
         end
         READOUT: begin
            // Issue a read while the two pipeline slots (output + skid) would
            // not overflow once this cycle's accept is taken into account.
            ram_re = (rd_cnt_q != len_q) && ((in_flight < 2'd2) || accept);
            if (accept && out_last_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = IDLE;
         ram_we  = 1'b0;
         ram_re  = 1'b0;
      end
   end

   // ----------------------------------------------------- control registers
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         len_q        <= FULL_LEN;
         mode_q       <= TRIG_SW;
         thr_q        <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == READOUT) && accept && out_last_q && !abort;

         if (state_q == IDLE && arm && !abort) begin
            len_q        <= (capture_len == '0 || capture_len > FULL_LEN) ? FULL_LEN : capture_len;
            mode_q       <= trig_mode;
            thr_q        <= trig_threshold;
            prev_valid_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
         end

         if (state_q == ARMED && adc_valid) begin
            prev_q       <= adc_data;
            prev_valid_q <= 1'b1;
         end

         if (ram_we) wr_cnt_q <= wr_cnt_q + CNT_ONE;
         if (ram_re) rd_cnt_q <= rd_cnt_q + CNT_ONE;
      end
   end

   // ------------------------------------------------------ readout pipeline
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_last_q  <= 1'b0;
         skid_data_q  <= '0;
      end else if (abort) begin
         pend_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         pend_q      <= ram_re;
         pend_last_q <= ram_re && rd_last;

         if (accept || !out_valid_q) begin
            // Output slot is free: refill from skid first to keep order.
            if (skid_valid_q) begin
               out_valid_q  <= 1'b1;
               out_data_q   <= skid_data_q;
               out_last_q   <= skid_last_q;
               skid_valid_q <= pend_q;
               skid_data_q  <= ram_rdata;
               skid_last_q  <= pend_last_q;
            end else begin
               out_valid_q <= pend_q;
               out_last_q  <= pend_q && pend_last_q;
               if (pend_q) out_data_q <= ram_rdata;
            end
         end else if (pend_q) begin
            // Output stalled: park the arriving read so m_data stays stable.
            skid_valid_q <= 1'b1;
            skid_data_q  <= ram_rdata;
            skid_last_q  <= pend_last_q;
         end
      end
   end

   syzygy_adc_capture_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (adc_data),
      .re    (ram_re),
      .raddr (rd_cnt_q[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign m_if.m_data  = out_data_q;
   assign m_if.m_valid = out_valid_q;
   assign m_if.m_last  = out_last_q;

endmodule

// File: tb/tb_syzygy_adc_capture.sv
// -----------------------------------------------------------------------------
// tb_syzygy_adc_capture
//  Directed bench for syzygy_adc_capture: reset, software and threshold
//  triggers, full-depth backpressure, length boundaries and abort recovery.
// -----------------------------------------------------------------------------
module tb_syzygy_adc_capture;

   localparam int DW    = 12;
   localparam int DEPTH = 1024;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] adc_data;
   logic          adc_valid;
   logic          arm, abort, trig_mode, sw_trigger;
   logic [DW-1:0] trig_threshold;
   logic [AW:0]   capture_len;
   logic          busy, done;

   syzygy_adc_capture_if #(.DATA_WIDTH(DW)) m_if ();

   syzygy_adc_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .adc_data       (adc_data),
      .adc_valid      (adc_valid),
      .arm            (arm),
      .abort          (abort),
      .trig_mode      (trig_mode),
      .sw_trigger     (sw_trigger),
      .trig_threshold (trig_threshold),
      .capture_len    (capture_len),
      .busy           (busy),
      .done           (done),
      .m_if           (m_if.master)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] ramp = '0;
   bit            manual_adc = 1'b0;
   bit            gap_mode = 1'b0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] first;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and drive the ADC ramp for the coming
   // rising edge; the ramp only advances on valid samples.
   task automatic tick();
      @(negedge clk);
      if (!manual_adc) begin
         adc_valid = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (adc_valid) begin
            adc_data = ramp;
            ramp     = ramp + 1'b1;
         end
      end
   endtask

   task automatic fill_ramp(input logic [DW-1:0] start, input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(start + DW'(i));
   endtask

   // Arm in software mode and fire the trigger; returns the first sample
   // value that will land in the buffer.
   task automatic start_sw(input logic [AW:0] len, output logic [DW-1:0] first_val);
      tick();
      arm = 1'b1; trig_mode = 1'b0; capture_len = len;
      tick();
      arm = 1'b0;
      check("armed_busy", busy, 1);
      sw_trigger = 1'b1;
      first_val  = ramp;
      tick();
      sw_trigger = 1'b0;
   endtask

   // Drain a burst against exp_q, checking order, m_last, stall stability
   // and a single done pulse.
   task automatic collect(input int n, input bit rand_rdy, input int budget);
      int            beat = 0;
      bit            stall = 1'b0;
      bit            exp_done = 1'b0;
      bit            got_done = 1'b0;
      logic [DW-1:0] held_d = '0;
      logic          held_l = 1'b0;
      for (int c = 0; c < budget && !got_done; c++) begin
         tick();
         m_if.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         check("done", done, exp_done);
         if (exp_done) begin
            check("busy_after_done", busy, 0);
            check("valid_after_done", m_if.m_valid, 0);
            got_done = 1'b1;
         end else begin
            if (stall) begin
               check("hold_valid", m_if.m_valid, 1);
               check("hold_data", m_if.m_data, held_d);
               check("hold_last", m_if.m_last, held_l);
            end
            if (m_if.m_valid) begin
               if (beat < n) check("data", m_if.m_data, exp_q[beat]);
               else          check("extra_beat", beat, n - 1);
               check("last", m_if.m_last, (beat == n - 1));
               held_d = m_if.m_data;
               held_l = m_if.m_last;
               stall  = !m_if.m_ready;
               if (m_if.m_ready) begin
                  if (beat == n - 1) exp_done = 1'b1;
                  beat++;
               end
            end else begin
               stall = 1'b0;
            end
         end
      end
      m_if.m_ready = 1'b0;
      check("beats", beat, n);
      check("done_seen", got_done, 1);
      tick();
      check("done_width", done, 0);
   endtask

   initial begin
      reset_n = 1'b0; arm = 1'b1; abort = 1'b0; trig_mode = 1'b0; sw_trigger = 1'b0;
      trig_threshold = '0; capture_len = '0; adc_data = '0; adc_valid = 1'b1;
      m_if.m_ready = 1'b0;

      // Reset held with arm and adc_valid active.
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_busy", busy, 0);
         check("rst_valid", m_if.m_valid, 0);
         check("rst_done", done, 0);
      end
      check("rst_data", m_if.m_data, 0);
      check("rst_last", m_if.m_last, 0);
      arm = 1'b0; reset_n = 1'b1;
      tick();
      check("idle_busy", busy, 0);

      // Software trigger, len 8, continuous ramp, ready high.
      start_sw(11'd8, first);
      fill_ramp(first, 8);
      collect(8, 1'b0, 100);

      // Threshold 0x800: an initial 0x900 must not trigger; 0x7FF->0x800 does.
      manual_adc = 1'b1; adc_valid = 1'b0;
      tick();
      arm = 1'b1; trig_mode = 1'b1; trig_threshold = 12'h800; capture_len = 11'd4;
      tick();
      arm = 1'b0; trig_threshold = 12'hFFF;  // must have been latched at arm
      adc_valid = 1'b1; adc_data = 12'h900;
      tick(); adc_data = 12'h7F0;
      tick(); adc_data = 12'h7FF;
      tick(); adc_data = 12'h800;
      tick(); adc_data = 12'h900;
      tick(); adc_data = 12'hA00;
      tick(); adc_data = 12'h100;
      exp_q.delete();
      exp_q.push_back(12'h800); exp_q.push_back(12'h900);
      exp_q.push_back(12'hA00); exp_q.push_back(12'h100);
      collect(4, 1'b0, 100);
      adc_valid = 1'b0;
      manual_adc = 1'b0;

      // Full depth with adc_valid gaps and random ready.
      gap_mode = 1'b1;
      start_sw(11'(DEPTH), first);
      fill_ramp(first, DEPTH);
      collect(DEPTH, 1'b1, 12000);
      gap_mode = 1'b0;

      // Length 0 clamps to DEPTH.
      start_sw(11'd0, first);
      fill_ramp(first, DEPTH);
      collect(DEPTH, 1'b0, 4000);

      // Length 1: a single beat carrying m_last.
      start_sw(11'd1, first);
      fill_ramp(first, 1);
      collect(1, 1'b0, 50);

      // Abort mid-capture.
      start_sw(11'd16, first);
      tick(); tick(); tick();
      check("cap_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_cap_busy", busy, 0);
      check("abort_cap_valid", m_if.m_valid, 0);
      check("abort_cap_done", done, 0);

      // Abort mid-readout with a beat pending.
      start_sw(11'd8, first);
      for (int c = 0; c < 40 && !m_if.m_valid; c++) tick();
      check("ro_valid_seen", m_if.m_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ro_valid", m_if.m_valid, 0);
      check("abort_ro_busy", busy, 0);
      check("abort_ro_done", done, 0);
      tick();
      check("abort_ro_done2", done, 0);

      // arm together with abort stays idle.
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      check("arm_abort_busy", busy, 0);

      // Recovery capture after aborts.
      start_sw(11'd4, first);
      fill_ramp(first, 4);
      collect(4, 1'b0, 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
